// File: rtl/div.sv
// Iterative 32/32 integer divider for a pipelined CPU ex stage.
// Signed and unsigned modes. Restoring shift-subtract, one quotient bit per
// clock, so a nonzero divisor yields a result 33 edges after the request
// is accepted. Divide by zero finishes in one edge with an all-zero result.
// result = {remainder, quotient}; ready and result come straight from flops.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        annul,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    // Working register: [64:32] partial remainder, [31:0] dividend bits
    // shifting out at the top while quotient bits shift in at the bottom.
    logic [64:0] work_reg, work_next;
    logic [31:0] divisor_reg, divisor_next;
    // Sign fix-up decisions are taken from the operands seen at acceptance,
    // so later operand changes cannot disturb the result.
    logic        neg_quo_reg, neg_quo_next;
    logic        neg_rem_reg, neg_rem_next;
    logic [63:0] result_reg, result_next;
    logic        ready_reg, ready_next;

    logic [31:0] mag1, mag2;
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fixed, rem_fixed;

    // Operand magnitudes, trial subtraction and final sign correction.
    always_comb begin
        mag1      = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
        mag2      = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
        shifted   = {work_reg[63:0], 1'b0};
        trial     = shifted[64:32] - {1'b0, divisor_reg};
        quo_fixed = neg_quo_reg ? (~work_reg[31:0] + 32'd1) : work_reg[31:0];
        rem_fixed = neg_rem_reg ? (~work_reg[63:32] + 32'd1) : work_reg[63:32];
    end

    // Next-state and datapath update; annul wins over completion.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        neg_quo_next = neg_quo_reg;
        neg_rem_next = neg_rem_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;
        case (state_reg)
            FREE: begin
                result_next = 64'h0;
                ready_next  = 1'b0;
                if (start && !annul) begin
                    if (opdata2 == 32'h0) begin
                        state_next = BY_ZERO;
                    end else begin
                        state_next   = ON;
                        work_next    = {33'h0, mag1};
                        divisor_next = mag2;
                        cnt_next     = 6'd0;
                        neg_quo_next = signed_div & (opdata1[31] ^ opdata2[31]);
                        neg_rem_next = signed_div & opdata1[31];
                    end
                end
            end
            BY_ZERO: begin
                result_next = 64'h0;
                if (annul) begin
                    state_next = FREE;
                    ready_next = 1'b0;
                end else begin
                    state_next = END;
                    ready_next = 1'b1;
                end
            end
            ON: begin
                if (annul) begin
                    state_next  = FREE;
                    ready_next  = 1'b0;
                    result_next = 64'h0;
                end else if (cnt_reg != 6'd32) begin
                    // Restoring step: keep the subtraction only if non-negative.
                    if (!trial[32]) begin
                        work_next = {trial, shifted[31:1], 1'b1};
                    end else begin
                        work_next = shifted;
                    end
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = END;
                    result_next = {rem_fixed, quo_fixed};
                    ready_next  = 1'b1;
                end
            end
            END: begin
                if (!start) begin
                    state_next  = FREE;
                    ready_next  = 1'b0;
                    result_next = 64'h0;
                end
            end
            default: begin
                state_next  = FREE;
                ready_next  = 1'b0;
                result_next = 64'h0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FREE;
            cnt_reg     <= 6'd0;
            work_reg    <= 65'h0;
            divisor_reg <= 32'h0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= 64'h0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            neg_quo_reg <= neg_quo_next;
            neg_rem_reg <= neg_rem_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign result = result_reg;
    assign ready  = ready_reg;

endmodule
